mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous SRAM (valid/ready handshake, memory ready one cycle after valid) among NREQ requesters.
- Latches the winning request, runs exactly one memory transaction, then returns read data and a done pulse to the winner.
- Sits between the requester masters and the memory instance; memory outputs feed the arbiter directly.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_WIDTH, 3, memory address width
WIDTH, 8, memory data width
TIMEOUT, 15, max WAIT cycles before abort (used only with optional feature)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset, shared with memory
req_valid  input  NREQ  per-requester request; held high until own req_done
req_wr_en  input  NREQ  per-requester write(1)/read(0)
req_addr  input  NREQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
req_grant  output  NREQ  one-hot current owner, registered; 0 when idle
req_done  output  NREQ  one-cycle completion pulse to owner
req_rdata  output  WIDTH  read data, valid only while req_done is high for a read
req_err  output  1  timeout flag, qualified by req_done
mem_valid  output  1  to memory valid
mem_wr_en  output  1  to memory wr_en
mem_addr  output  ADDR_WIDTH  to memory addr
mem_wdata  output  WIDTH  to memory wdata
mem_ready  input  1  from memory ready
mem_rdata  input  WIDTH  from memory rdata

Behaviour:
- Reset: clk, rst; rst synchronous, active-high. All outputs 0, state IDLE, priority pointer 0. Reset mid-operation aborts the transaction with no done pulse.
- All outputs are registered.
- IDLE:
  - If any req_valid is high, select the first set bit at or after the pointer, wrapping NREQ-1 to 0.
  - Latch wr_en, addr and wdata of the winner into the mem_* registers, set req_grant, go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE: mem_valid=1 for exactly one cycle, then go to WAIT.
- WAIT: mem_valid=0. When mem_ready is sampled high:
  - For a read, capture mem_rdata into req_rdata.
  - Go to DONE.
  - If mem_ready is low, remain in WAIT.
- DONE:
  - req_done[owner]=1 for one cycle.
  - Pointer becomes owner+1, wrapping at NREQ.
  - req_grant cleared on exit. Go to IDLE.
- Latency and throughput:
  - Edge sampling req_valid = E0. mem_valid is high in cycle E0..E1. req_done is high in cycle E2..E3.
  - Occupancy is 4 cycles per transaction; maximum throughput is 1 transaction per 4 cycles.
- Requester rule:
  - Drop or refresh req_valid on the edge that ends its req_done cycle.
  - The arbiter ignores req_valid outside IDLE.
  - Changes to req_addr, req_wdata or req_wr_en after grant have no effect.
- req_rdata holds its last value outside read completions; writes leave it unchanged.
- Simultaneous requests: strict round-robin.
  - After requester k is served, k has lowest priority.
  - A lone requester may be served back-to-back, one transaction per 4 cycles.

Optional Feature:
- Macro MEM_RR_ARBITER_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs in WAIT.
  - If it reaches TIMEOUT with mem_ready still low, go to DONE with req_err=1 and req_rdata unchanged.
  - Pointer advances as normal; the counter clears on leaving WAIT.
- Undefined:
  - No counter; WAIT persists until mem_ready.
  - req_err is tied to 0.

Test Plan:
1. Reset, then requester 0 writes 0xA5 to addr 3, then reads addr 3 -> each req_done[0] comes 3 cycles after sampling; read returns req_rdata=0xA5.
2. All four req_valid held high with distinct reads, pointer 0 -> grants in order 0,1,2,3,0; one req_done every 4 cycles.
3. Requester 2 alone, back-to-back writes of 0x11..0x14 to addr 4..7 -> each completes; read-back of addr 4..7 returns 0x11..0x14.
4. Assert rst during WAIT of requester 1 -> no req_done; all outputs 0 next cycle; pointer 0; memory cleared (read addr 3 returns 0).
5. With MEM_RR_ARBITER_TIMEOUT_EN and mem_ready forced 0 -> req_done with req_err=1 after 15 WAIT cycles; without the macro -> no req_done, grant held.
6. Requester 1 changes req_addr from 2 to 5 after grant -> memory access occurs at addr 2.

Source files
------------

// File: rtl/mem_rr_arbiter_if.sv
// Requester and memory-side signal bundle for mem_rr_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus the SRAM.
interface mem_rr_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 8
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_wr_en;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]      req_wdata;
  logic [NREQ-1:0]            req_grant;
  logic [NREQ-1:0]            req_done;
  logic [WIDTH-1:0]           req_rdata;
  logic                       req_err;
  logic                       mem_valid;
  logic                       mem_wr_en;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [WIDTH-1:0]           mem_wdata;
  logic                       mem_ready;
  logic [WIDTH-1:0]           mem_rdata;

  modport master (
    input  req_valid, req_wr_en, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_grant, req_done, req_rdata, req_err,
    output mem_valid, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_wr_en, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_grant, req_done, req_rdata, req_err,
    input  mem_valid, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NREQ requesters, one transaction at a time.
// Optional WAIT timeout enabled by defining MEM_RR_ARBITER_TIMEOUT_EN.
module mem_rr_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_rr_arbiter_if.master  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_rr_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         own;
  logic [NREQ-1:0]       grant_q;
  logic [NREQ-1:0]       done_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  mem_valid_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;

  logic                  win_found;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         cand;

  // Scan from the pointer upward with wrap; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      own         <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            own         <= win_idx;
            grant_q     <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            mem_valid_q <= 1'b1;
            mem_wr_q    <= bus.req_wr_en[win_idx];
            mem_addr_q  <= bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_q <= bus.req_wdata[win_idx*WIDTH +: WIDTH];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_valid_q <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.mem_ready) begin
            if (!mem_wr_q) rdata_q <= bus.mem_rdata;
            done_q <= grant_q;
            state  <= DONE;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Abort: complete with error, leaving read data untouched.
            done_q   <= grant_q;
            err_q    <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr     <= (own == IW'(NREQ - 1)) ? '0 : own + 1'b1;
          state   <= IDLE;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_grant = grant_q;
  assign bus.req_done  = done_q;
  assign bus.req_rdata = rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_wr_en = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
  assign bus.req_err   = err_q;
`else
  assign bus.req_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural single-port SRAM (ready one cycle after valid).
module tb_mem_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  mem_rr_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .WIDTH(DW), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model sharing the arbiter reset; stall suppresses ready.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= bus.mem_valid & ~stall;
      if (bus.mem_valid) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        else               bus.mem_rdata     <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit wr, input int a, input int d);
    bus.req_valid[k]            = 1'b1;
    bus.req_wr_en[k]            = wr;
    bus.req_addr[k*AW +: AW]    = AW'(a);
    bus.req_wdata[k*DW +: DW]   = DW'(d);
  endtask

  task automatic wait_any(input int maxc, output int lat, output bit found);
    lat = 0;
    found = 1'b0;
    while (lat < maxc) begin
      tick();
      lat++;
      if (bus.req_done != '0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Lone transaction from an idle arbiter: done must appear 3 edges later.
  task automatic txn(input int k, input bit wr, input int a, input int d, input string tag);
    int lat;
    bit found;
    set_req(k, wr, a, d);
    wait_any(20, lat, found);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_done"}, bus.req_done, 32'(1 << k));
    check({tag, "_err"}, bus.req_err, 0);
    bus.req_valid[k] = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    bit found;
    bus.req_valid = '0;
    bus.req_wr_en = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_grant", bus.req_grant, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_memvalid", bus.mem_valid, 0);
    check("rst_rdata", bus.req_rdata, 0);
    rst = 1'b0;
    tick();

    // Requester 0 write then read of addr 3, with cycle-by-cycle view of the first.
    set_req(0, 1'b1, 3, 8'hA5);
    tick();
    check("t1_grant", bus.req_grant, 4'b0001);
    check("t1_memvalid", bus.mem_valid, 1);
    check("t1_memaddr", bus.mem_addr, 3);
    check("t1_memwr", bus.mem_wr_en, 1);
    check("t1_memwdata", bus.mem_wdata, 8'hA5);
    tick();
    check("t1_memvalid_low", bus.mem_valid, 0);
    check("t1_nodone_early", bus.req_done, 0);
    tick();
    check("t1_done", bus.req_done, 4'b0001);
    bus.req_valid[0] = 1'b0;
    tick();
    check("t1_grant_clr", bus.req_grant, 0);
    check("t1_done_clr", bus.req_done, 0);
    txn(0, 1'b0, 3, 0, "t1_rd");
    check("t1_rdata", bus.req_rdata, 8'hA5);

    // Requester 3 fills addr 0..3; pointer ends at 0, writes leave rdata alone.
    for (int i = 0; i < 4; i++) txn(3, 1'b1, i, 8'hC0 + i, "fill");
    check("fill_rdata_kept", bus.req_rdata, 8'hA5);

    // All four hold reads of their own address; order 0,1,2,3,0 every 4 cycles.
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, k, 0);
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % 4;
      wait_any(20, lat, found);
      check("t2_interval", lat, (n == 0) ? 3 : 4);
      check("t2_order", bus.req_done, 32'(1 << e));
      check("t2_rdata", bus.req_rdata, 8'hC0 + e);
    end
    bus.req_valid = '0;
    tick();

    // Requester 2 alone: back-to-back writes then read-back.
    for (int i = 0; i < 4; i++) txn(2, 1'b1, 4 + i, 8'h11 + i, "t3_wr");
    for (int i = 0; i < 4; i++) begin
      txn(2, 1'b0, 4 + i, 0, "t3_rd");
      check("t3_rdata", bus.req_rdata, 8'h11 + i);
    end

    // Address change after grant must not affect the access.
    set_req(1, 1'b0, 2, 0);
    tick();
    check("t6_grant", bus.req_grant, 4'b0010);
    bus.req_addr[1*AW +: AW] = 3'd5;
    wait_any(20, lat, found);
    check("t6_lat", lat, 2);
    check("t6_memaddr", bus.mem_addr, 2);
    check("t6_rdata", bus.req_rdata, 8'hC2);
    bus.req_valid[1] = 1'b0;
    tick();

    // Reset while requester 1 sits in WAIT.
    set_req(1, 1'b0, 6, 0);
    tick();
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    check("t4_grant", bus.req_grant, 0);
    check("t4_done", bus.req_done, 0);
    check("t4_memvalid", bus.mem_valid, 0);
    check("t4_memaddr", bus.mem_addr, 0);
    check("t4_rdata", bus.req_rdata, 0);
    rst = 1'b0;
    tick();
    check("t4_nodone_after", bus.req_done, 0);
    set_req(0, 1'b0, 3, 0);
    set_req(1, 1'b0, 3, 0);
    wait_any(20, lat, found);
    check("t4_ptr0_first", bus.req_done, 4'b0001);
    check("t4_mem_cleared", bus.req_rdata, 0);
    bus.req_valid[0] = 1'b0;
    wait_any(20, lat, found);
    check("t4_second", bus.req_done, 4'b0010);
    bus.req_valid[1] = 1'b0;
    tick();

    // Memory never answers.
    stall = 1'b1;
    set_req(0, 1'b1, 5, 8'h77);
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    wait_any(40, lat, found);
    check("t5_found", found, 1);
    check("t5_lat", lat, 17);
    check("t5_done", bus.req_done, 4'b0001);
    check("t5_err", bus.req_err, 1);
    check("t5_rdata_kept", bus.req_rdata, 0);
    bus.req_valid[0] = 1'b0;
    tick();
    check("t5_err_clr", bus.req_err, 0);
`else
    wait_any(40, lat, found);
    check("t5_nodone", found, 0);
    check("t5_grant_held", bus.req_grant, 4'b0001);
    check("t5_err", bus.req_err, 0);
    bus.req_valid[0] = 1'b0;
`endif
    stall = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("end_idle", bus.req_grant, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
